// File: rtl/branch_resolve_pc.sv
// Branch resolution and fetch PC ownership.
// Evaluates EX branches/jumps, redirects the PC, and holds a flush window.
module branch_resolve_pc #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  pcEn,
  input  logic                  takeBranch,
  input  logic [2:0]            branchType,
  input  logic                  jump,
  input  logic                  jumpReg,
  input  logic [DATA_WIDTH-1:0] rs1Data,
  input  logic [DATA_WIDTH-1:0] rs2Data,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] instrPc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pcPlus4,
  output logic                  redirect,
  output logic                  flush,
  output logic                  misaligned
);

  localparam int CW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'(FLUSH_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] FOUR =
    DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] tgt;
  logic [CW-1:0]         cnt;

  logic                  eq;
  logic                  slt;
  logic                  ult;
  logic                  cond;
  logic                  decide;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] br_tgt;
  logic [DATA_WIDTH-1:0] jr_sum;
  logic [DATA_WIDTH-1:0] jr_tgt;
  logic [DATA_WIDTH-1:0] target;

  assign pcPlus4 = pc + FOUR;

  assign eq  = (rs1Data == rs2Data);
  assign slt = ($signed(rs1Data) < $signed(rs2Data));
  assign ult = (rs1Data < rs2Data);

  // Branch condition from the decoded funct3 code
  always_comb begin
    cond = 1'b0;
    case (branchType)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = slt;
      3'b101:  cond = !slt;
      3'b110:  cond = ult;
      3'b111:  cond = !ult;
      default: cond = 1'b0;
    endcase
  end

  assign br_tgt = instrPc + imm;
  assign jr_sum = rs1Data + imm;
  assign jr_tgt = {jr_sum[DATA_WIDTH-1:1], 1'b0};

  // JALR target wins over JAL/branch, which share one adder
  assign target  = jumpReg ? jr_tgt : br_tgt;
  assign decide  = jumpReg | jump | (takeBranch & cond);
  assign aligned = (target[1:0] == 2'b00);

  // Redirect sequencer: PC, target latch, flush window, flags.
  // The PC takes the target on the decision edge so it is visible
  // in the same cycle redirect is high; pcEn cannot block it.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= RUN;
      pc         <= RESET_PC;
      tgt        <= '0;
      cnt        <= '0;
      redirect   <= 1'b0;
      flush      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      redirect   <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        RUN: begin
          if (decide && aligned) begin
            pc       <= target;
            tgt      <= target;
            cnt      <= CNT_INIT;
            redirect <= 1'b1;
            flush    <= 1'b1;
            state    <= REDIRECT;
          end else begin
            if (pcEn) pc <= pc + FOUR;
            if (decide) misaligned <= 1'b1;
            flush <= 1'b0;
          end
        end
        REDIRECT: begin
          pc <= pcEn ? tgt + FOUR : tgt;
          if (FLUSH_CYCLES > 1) begin
            cnt   <= cnt - 1'b1;
            flush <= 1'b1;
            state <= FLUSH;
          end else begin
            flush <= 1'b0;
            state <= RUN;
          end
        end
        FLUSH: begin
          if (pcEn) begin
            pc <= pc + FOUR;
            if (cnt == '0) begin
              flush <= 1'b0;
              state <= RUN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          flush <= 1'b0;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_pc.sv
// Directed bench for branch_resolve_pc.
// Hand-computed PC/flag expectations, default parameters.
module tb_branch_resolve_pc;

  logic        clk;
  logic        rstN;
  logic        pcEn;
  logic        takeBranch;
  logic [2:0]  branchType;
  logic        jump;
  logic        jumpReg;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] imm;
  logic [31:0] instrPc;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        redirect;
  logic        flush;
  logic        misaligned;

  int passed;
  int total;

  branch_resolve_pc dut (
    .clk        (clk),
    .rstN       (rstN),
    .pcEn       (pcEn),
    .takeBranch (takeBranch),
    .branchType (branchType),
    .jump       (jump),
    .jumpReg    (jumpReg),
    .rs1Data    (rs1Data),
    .rs2Data    (rs2Data),
    .imm        (imm),
    .instrPc    (instrPc),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .redirect   (redirect),
    .flush      (flush),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // pc, redirect, flush, misaligned in one call
  task automatic chk_all(input string tag,
                         input logic [31:0] epc,
                         input logic er,
                         input logic ef,
                         input logic em);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".redirect"}, 32'(redirect), 32'(er));
    chk({tag, ".flush"}, 32'(flush), 32'(ef));
    chk({tag, ".misaligned"}, 32'(misaligned), 32'(em));
  endtask

  task automatic idle();
    takeBranch = 1'b0;
    branchType = 3'b000;
    jump       = 1'b0;
    jumpReg    = 1'b0;
    rs1Data    = '0;
    rs2Data    = '0;
    imm        = '0;
    instrPc    = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rstN   = 1'b0;
    pcEn   = 1'b0;
    idle();
    tick();
    tick();
    chk_all("reset", 32'h0, 0, 0, 0);
    chk("reset.pcPlus4", pcPlus4, 32'h4);

    // sequential fetch
    rstN = 1'b1;
    pcEn = 1'b1;
    tick();
    chk_all("seq1", 32'h4, 0, 0, 0);
    tick();
    chk_all("seq2", 32'h8, 0, 0, 0);
    tick();
    chk_all("seq3", 32'hC, 0, 0, 0);
    chk("seq3.pcPlus4", pcPlus4, 32'h10);

    // BEQ taken -> 0x120
    takeBranch = 1'b1;
    branchType = 3'b000;
    rs1Data    = 32'd5;
    rs2Data    = 32'd5;
    instrPc    = 32'h100;
    imm        = 32'h20;
    tick();
    idle();
    chk_all("beq.redir", 32'h120, 1, 1, 0);
    tick();
    chk_all("beq.flush", 32'h124, 0, 1, 0);
    tick();
    chk_all("beq.done", 32'h128, 0, 0, 0);

    // BLT signed -1 < 1 taken -> 0x210
    takeBranch = 1'b1;
    branchType = 3'b100;
    rs1Data    = 32'hFFFF_FFFF;
    rs2Data    = 32'd1;
    instrPc    = 32'h200;
    imm        = 32'h10;
    tick();
    chk_all("blt.redir", 32'h210, 1, 1, 0);
    idle();
    tick();
    chk_all("blt.flush", 32'h214, 0, 1, 0);
    tick();
    chk_all("blt.done", 32'h218, 0, 0, 0);

    // BLTU same operands: not taken
    takeBranch = 1'b1;
    branchType = 3'b110;
    rs1Data    = 32'hFFFF_FFFF;
    rs2Data    = 32'd1;
    instrPc    = 32'h200;
    imm        = 32'h10;
    tick();
    chk_all("bltu.nt", 32'h21C, 0, 0, 0);
    idle();

    // JALR misaligned 0x203 -> 0x202
    jumpReg = 1'b1;
    rs1Data = 32'h203;
    tick();
    chk_all("jalr.mis", 32'h220, 0, 0, 1);
    idle();
    tick();
    chk_all("jalr.mis_end", 32'h224, 0, 0, 0);

    // JALR 0x201 -> 0x200 (bit 0 cleared)
    jumpReg = 1'b1;
    rs1Data = 32'h201;
    tick();
    chk_all("jalr.redir", 32'h200, 1, 1, 0);
    idle();
    tick();
    chk_all("jalr.flush", 32'h204, 0, 1, 0);

    // taken branch during FLUSH is ignored
    takeBranch = 1'b1;
    branchType = 3'b000;
    instrPc    = 32'h300;
    imm        = 32'h40;
    tick();
    chk_all("flush.ign", 32'h208, 0, 0, 0);
    idle();
    tick();
    chk_all("flush.ign2", 32'h20C, 0, 0, 0);

    // JAL + not-taken BNE: JAL wins -> 0x440
    jump       = 1'b1;
    takeBranch = 1'b1;
    branchType = 3'b001;
    rs1Data    = 32'd7;
    rs2Data    = 32'd7;
    instrPc    = 32'h400;
    imm        = 32'h40;
    tick();
    chk_all("jal.redir", 32'h440, 1, 1, 0);
    idle();
    tick();
    tick();
    chk_all("jal.done", 32'h448, 0, 0, 0);

    // JALR + JAL together: JALR wins -> 0x1040
    jumpReg = 1'b1;
    jump    = 1'b1;
    rs1Data = 32'h1000;
    instrPc = 32'h400;
    imm     = 32'h40;
    tick();
    chk_all("prio.redir", 32'h1040, 1, 1, 0);
    idle();
    tick();
    tick();
    chk_all("prio.done", 32'h1048, 0, 0, 0);

    // stall: decision and window with pcEn=0
    pcEn       = 1'b0;
    takeBranch = 1'b1;
    branchType = 3'b000;
    instrPc    = 32'h500;
    imm        = 32'h8;
    tick();
    chk_all("stall.redir", 32'h508, 1, 1, 0);
    idle();
    tick();
    chk_all("stall.f1", 32'h508, 0, 1, 0);
    tick();
    chk_all("stall.f2", 32'h508, 0, 1, 0);
    tick();
    chk_all("stall.f3", 32'h508, 0, 1, 0);
    pcEn = 1'b1;
    tick();
    chk_all("stall.done", 32'h50C, 0, 0, 0);

    // reset mid-FLUSH
    takeBranch = 1'b1;
    branchType = 3'b000;
    instrPc    = 32'h600;
    imm        = 32'h0;
    tick();
    chk_all("rst.redir", 32'h600, 1, 1, 0);
    idle();
    tick();
    chk_all("rst.flush", 32'h604, 0, 1, 0);
    rstN = 1'b0;
    tick();
    chk_all("rst.mid", 32'h0, 0, 0, 0);
    rstN = 1'b1;
    tick();
    chk_all("rst.after", 32'h4, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
